rv_mem_harness: RTL



---
 rtl/rv_mem_if.sv | 32 +++
 rtl/rv_mem_harness.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rv_mem_if.sv
// Bus bundle between a core bench (master) and the rv_mem_harness memory model (slave).
// Carries fetch, load, store and the status/mailbox outputs.
interface rv_mem_if #(
    parameter int PC_LEN = 32,
    parameter int CNT_W  = 32
);
    logic [PC_LEN-1:0] pc;
    logic [31:0]       instr;
    logic              c_dmem_load;
    logic [PC_LEN-1:0] dmem_load_addr;
    logic [31:0]       dmem_load_data;
    logic              c_dmem_store;
    logic [PC_LEN-1:0] dmem_store_addr;
    logic [1:0]        dmem_store_width;
    logic [31:0]       dmem_store_data;
    logic              c_halt;
    logic [30:0]       halt_code;
    logic [CNT_W-1:0]  store_count;
    logic              c_addr_err;

    modport master (
        output pc, c_dmem_load, dmem_load_addr,
               c_dmem_store, dmem_store_addr, dmem_store_width, dmem_store_data,
        input  instr, dmem_load_data, c_halt, halt_code, store_count, c_addr_err
    );

    modport slave (
        input  pc, c_dmem_load, dmem_load_addr,
               c_dmem_store, dmem_store_addr, dmem_store_width, dmem_store_data,
        output instr, dmem_load_data, c_halt, halt_code, store_count, c_addr_err
    );
endinterface

// File: rtl/rv_mem_harness.sv
// Unified instruction/data memory model with halfword fetch, load pipe and byte-lane stores.
// Optional RV_MEM_HALT_EN enables the tohost mailbox that raises c_halt.
module rv_mem_harness #(
    parameter int                PC_LEN      = 32,
    parameter int                MEM_DEPTH   = 16384,
    parameter logic [PC_LEN-1:0] MEM_BASE    = '0,
    parameter int                LOAD_LAT    = 1,
    parameter logic [PC_LEN-1:0] TOHOST_ADDR = PC_LEN'(32'h8000_1000),
    parameter int                CNT_W       = 32
) (
    input logic   clk,
    input logic   c_arst,
    rv_mem_if.slave bus
);
    localparam int                AW        = $clog2(MEM_DEPTH);
    localparam logic [PC_LEN:0]   MEM_BYTES = (PC_LEN+1)'(4 * MEM_DEPTH);

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2,
        W_RSVD = 2'd3
    } store_width_e;

    logic [31:0] mem [MEM_DEPTH];

    function automatic logic in_range(input logic [PC_LEN-1:0] addr);
        logic [PC_LEN-1:0] off;
        off = addr - MEM_BASE;
        return {1'b0, off} < MEM_BYTES;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [PC_LEN-1:0] addr);
        logic [PC_LEN-1:0] off;
        off = addr - MEM_BASE;
        return off[AW+1:2];
    endfunction

    // ---------------- fetch ----------------
    logic [AW-1:0] fw, fw_next;
    logic          fetch_err;

    assign fw        = word_idx(bus.pc);
    assign fw_next   = fw + 1'b1;  // wraps to word 0 past the top of the array
    assign fetch_err = bus.pc[0] || !in_range(bus.pc);

    always_comb begin
        if (fetch_err)      bus.instr = '0;
        else if (bus.pc[1]) bus.instr = {mem[fw_next][15:0], mem[fw][31:16]};
        else                bus.instr = mem[fw];
    end

    // ---------------- load ----------------
    logic        load_err;
    logic [31:0] load_word;

    assign load_err  = bus.c_dmem_load && !in_range(bus.dmem_load_addr);
    assign load_word = (bus.c_dmem_load && !load_err) ? mem[word_idx(bus.dmem_load_addr)] : '0;

    generate
        if (LOAD_LAT == 0) begin : g_load_comb
            assign bus.dmem_load_data = load_word;
        end else begin : g_load_pipe
            logic [31:0] pipe [LOAD_LAT];
            // Sampling mem at the same edge as a store yields pre-store data.
            always_ff @(posedge clk or negedge c_arst) begin
                if (!c_arst) begin
                    for (int i = 0; i < LOAD_LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= load_word;
                    for (int i = 1; i < LOAD_LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign bus.dmem_load_data = pipe[LOAD_LAT-1];
        end
    endgenerate

    // ---------------- store decode ----------------
    store_width_e  st_width;
    logic          st_aligned, st_legal, st_commit, st_err, st_halt, halted;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [AW-1:0] sw;

    assign st_width = store_width_e'(bus.dmem_store_width);
    assign sw       = word_idx(bus.dmem_store_addr);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        st_aligned = 1'b0;
        st_be      = 4'b0000;
        st_wdata   = bus.dmem_store_data;
        unique case (st_width)
            W_BYTE: begin
                st_aligned = 1'b1;
                st_be      = 4'b0001 << bus.dmem_store_addr[1:0];
                st_wdata   = {4{bus.dmem_store_data[7:0]}};
            end
            W_HALF: begin
                st_aligned = !bus.dmem_store_addr[0];
                st_be      = bus.dmem_store_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata   = {2{bus.dmem_store_data[15:0]}};
            end
            W_WORD: begin
                st_aligned = (bus.dmem_store_addr[1:0] == 2'b00);
                st_be      = 4'b1111;
            end
            W_RSVD: st_aligned = 1'b0;
        endcase
    end

    assign st_legal = st_aligned && in_range(bus.dmem_store_addr);

    always_comb begin
        st_commit = 1'b0;
        st_err    = 1'b0;
        st_halt   = 1'b0;
        if (bus.c_dmem_store && !halted) begin
`ifdef RV_MEM_HALT_EN
            if (bus.dmem_store_addr == TOHOST_ADDR) begin
                if (st_width == W_WORD) st_halt = bus.dmem_store_data[0];
                else                    st_err  = 1'b1;
            end else
`endif
            if (st_legal) st_commit = 1'b1;
            else          st_err    = 1'b1;
        end
    end

    // NOTE: the array has no reset; contents survive c_arst like a real RAM.
    always_ff @(posedge clk) begin
        if (st_commit) begin
            for (int b = 0; b < 4; b++)
                if (st_be[b]) mem[sw][8*b +: 8] <= st_wdata[8*b +: 8];
        end
    end

    // ---------------- status ----------------
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge c_arst) begin
        if (!c_arst) begin
            bus.store_count <= '0;
            bus.c_addr_err  <= 1'b0;
        end else begin
            if (st_commit && (bus.store_count != '1))
                bus.store_count <= bus.store_count + 1'b1;
            if (fetch_err || load_err || st_err)
                bus.c_addr_err <= 1'b1;
        end
    end

`ifdef RV_MEM_HALT_EN
    always_ff @(posedge clk or negedge c_arst) begin
        if (!c_arst) begin
            bus.c_halt    <= 1'b0;
            bus.halt_code <= '0;
        end else if (st_halt) begin
            bus.c_halt    <= 1'b1;
            bus.halt_code <= bus.dmem_store_data[31:1];
        end
    end
    assign halted = bus.c_halt;
`else
    assign bus.c_halt    = 1'b0;
    assign bus.halt_code = '0;
    assign halted        = 1'b0;
`endif

endmodule
